// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// The state enum is used by the loader FSM; sizes describe the frame layout.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int LEN_BYTES         = 2;
  localparam int BYTES_PER_WORD    = 4;
  localparam int MAX_WORDS_DEFAULT = 4096;

endpackage

// File: rtl/word_packer.sv
// Packs a byte stream into 32-bit little-endian words; word_valid pulses for
// one cycle after the fourth byte of each word has been shifted in.
module word_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [IDX_W-1:0] idx;

  assign last = (idx == IDX_W'(BYTES_PER_WORD - 1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= valid && last;
      if (clear) begin
        idx <= '0;
      end else if (valid) begin
        idx  <= idx + IDX_W'(1);
        // First byte ends up in [7:0] after four shifts.
        word <= {data, word[31:8]};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream image loader: length header, little-endian payload words written
// to instruction RAM from address 0, trailing 8-bit payload checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              load_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  state_t          state;
  logic [7:0]      len_lo;
  logic [7:0]      sum;
  logic [ADDR_W:0] n_words;
  logic [15:0]     len;
  logic            xfer;
  logic            pack_valid;
  logic            pack_clear;
  logic            pack_last;
  logic            word_valid;
  logic [31:0]     word;

  assign xfer       = s_valid && s_ready;
  assign len        = {s_data, len_lo};
  assign pack_valid = xfer && (state == S_DATA);
  assign pack_clear = xfer && (state == S_LEN_HI);

  word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pack_clear),
    .valid      (pack_valid),
    .data       (s_data),
    .word       (word),
    .word_valid (word_valid),
    .last       (pack_last)
  );

  // The packer's registered pulse is the write strobe, one cycle after byte 3.
  assign mem_we    = word_valid;
  assign mem_wdata = word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LEN_LO;
      len_lo     <= '0;
      sum        <= '0;
      n_words    <= '0;
      mem_addr   <= '0;
      word_count <= '0;
      s_ready    <= 1'b1;
      cpu_rst_n  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      // Advance after each write except the last, so the address never wraps.
      if (word_valid && (word_count != n_words)) begin
        mem_addr <= mem_addr + ADDR_W'(1);
      end

      unique case (state)
        S_LEN_LO: begin
          if (xfer) begin
            len_lo <= s_data;
            state  <= S_LEN_HI;
            busy   <= 1'b1;
          end
        end

        S_LEN_HI: begin
          if (xfer) begin
            if ((len == 16'd0) || (32'(len) > MAX_WORDS)) begin
              state   <= S_ERR;
              err     <= 1'b1;
              busy    <= 1'b0;
              s_ready <= 1'b0;
            end else begin
              state    <= S_DATA;
              n_words  <= (ADDR_W+1)'(len);
              sum      <= '0;
              mem_addr <= '0;
            end
          end
        end

        S_DATA: begin
          if (xfer) begin
            sum <= sum + s_data;
            if (pack_last) begin
              word_count <= word_count + (ADDR_W+1)'(1);
              if ((word_count + (ADDR_W+1)'(1)) == n_words) begin
                state <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (xfer) begin
            busy    <= 1'b0;
            s_ready <= 1'b0;
            if (s_data == sum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end

        S_DONE, S_ERR: begin
          if (load_req) begin
            state      <= S_LEN_LO;
            s_ready    <= 1'b1;
            cpu_rst_n  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            word_count <= '0;
            mem_addr   <= '0;
          end
        end

        default: begin
          state <= S_LEN_LO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: frames are parsed by a byte-level model
// into expected RAM writes and final status, then compared with what the DUT did.
module tb_prog_loader;

  localparam int ADDR_W    = 12;
  localparam int MAX_WORDS = 4096;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              load_req = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [43:0] got_q[$];
  logic [43:0] exp_q[$];
  logic        exp_done;
  logic        prev_we = 1'b0;
  bq_t         fr;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .load_req   (load_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Write monitor: records every RAM write; strobe must be a single-cycle
  // pulse and word_count must already include the word being written.
  always @(negedge clk) begin
    if (mem_we) begin
      got_q.push_back({mem_addr, mem_wdata});
      n_checks++;
      if (prev_we || (word_count !== 13'(mem_addr) + 13'd1)) begin
        n_fail++;
        $display("FAIL mem_we_pulse: prev_we=%0b word_count=%0d addr=%0d", prev_we, word_count, mem_addr);
      end
    end
    prev_we = mem_we;
  end

  // Reference model: parse a complete frame into writes and final outcome.
  task automatic model(input bq_t f);
    int         n;
    logic [7:0] s;
    logic [31:0] d;
    exp_q.delete();
    n = int'({f[1], f[0]});
    if (n == 0 || n > MAX_WORDS) begin
      exp_done = 1'b0;
      return;
    end
    s = 8'd0;
    for (int w = 0; w < n; w++) begin
      d = 32'd0;
      for (int k = 0; k < 4; k++) begin
        d = d | (32'(f[2 + 4*w + k]) << (8*k));
        s = s + f[2 + 4*w + k];
      end
      exp_q.push_back({12'(w), d});
    end
    exp_done = (f[2 + 4*n] == s);
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap, input bit rnd_req);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      s_valid  = 1'b0;
      s_data   = 8'($urandom);
      load_req = rnd_req ? 1'($urandom) : 1'b0;
      @(negedge clk);
    end
    s_valid  = 1'b1;
    s_data   = b;
    load_req = rnd_req ? 1'($urandom) : 1'b0;
    @(negedge clk);
    s_valid  = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic restart();
    if (done || err) begin
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
      n_checks++;
      if ({cpu_rst_n, done, err, s_ready, busy} !== 5'b00010 || word_count !== 13'd0) begin
        n_fail++;
        $display("FAIL restart: rst/done/err/ready/busy=%b word_count=%0d want 00010 / 0",
                 {cpu_rst_n, done, err, s_ready, busy}, word_count);
      end
    end
  endtask

  task automatic run_frame(input bq_t f, input int gap, input bit rnd_req, input string name);
    logic [43:0] e;
    logic [43:0] g;
    restart();
    got_q.delete();
    model(f);
    foreach (f[i]) begin
      send_byte(f[i], gap, rnd_req);
      if (i == 0) begin
        n_checks++;
        if (busy !== 1'b1 || cpu_rst_n !== 1'b0) begin
          n_fail++;
          $display("FAIL %s busy_after_first: busy=%b cpu_rst_n=%b want 1 0", name, busy, cpu_rst_n);
        end
      end
    end
    n_checks++;
    if ({done, err, cpu_rst_n, busy, s_ready} !== {exp_done, !exp_done, exp_done, 2'b00}) begin
      n_fail++;
      $display("FAIL %s status: done/err/cpu_rst_n/busy/s_ready=%b want %b", name,
               {done, err, cpu_rst_n, busy, s_ready}, {exp_done, !exp_done, exp_done, 2'b00});
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (word_count !== 13'(exp_q.size()) || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: word_count=%0d writes=%0d want %0d", name, word_count, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        e = exp_q[i];
        g = got_q[i];
        n_checks++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL %s write[%0d]: addr=%h data=%h want addr=%h data=%h", name, i, g[43:32], g[31:0], e[43:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    n_checks++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err, word_count} !==
        {1'b1, 1'b0, 12'd0, 32'd0, 4'b0000, 13'd0}) begin
      n_fail++;
      $display("FAIL reset_values: ready=%b we=%b addr=%h wdata=%h rst=%b busy=%b done=%b err=%b wc=%0d",
               s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err, word_count);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    run_frame(fr, 0, 1'b0, "normal");
    n_checks++;
    if (exp_q.size() != 2 || !exp_done || exp_q[1] !== {12'd1, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL normal_model: writes=%0d done=%b", exp_q.size(), exp_done);
    end
  endtask

  task automatic test_bad_csum();
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4D};
    run_frame(fr, 0, 1'b0, "bad_csum");
  endtask

  task automatic test_header_errors();
    fr = '{8'h00, 8'h00};
    run_frame(fr, 0, 1'b0, "hdr_zero");
    fr = '{8'h01, 8'h10};
    run_frame(fr, 0, 1'b0, "hdr_big");
    fr = '{8'h00, 8'h00};
    fr[0] = 8'($urandom_range(255, 1));
    fr[1] = 8'($urandom_range(255, 17));
    run_frame(fr, 2, 1'b0, "hdr_rand");
  endtask

  task automatic test_throttled();
    int         n;
    logic [7:0] s;
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    run_frame(fr, 5, 1'b1, "throttled");
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(7, 1));
      fr.delete();
      fr.push_back(8'(n));
      fr.push_back(8'h00);
      s = 8'd0;
      for (int i = 0; i < 4*n; i++) begin
        fr.push_back(8'($urandom));
        s = s + fr[fr.size()-1];
      end
      fr.push_back(($urandom_range(3, 0) == 0) ? s ^ 8'(1 << $urandom_range(7, 0)) : s);
      run_frame(fr, 5, 1'b1, "random");
    end
  endtask

  task automatic test_reset_reload();
    fr = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h4C};
    restart();
    got_q.delete();
    for (int i = 0; i < 5; i++) send_byte(fr[i], 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err, word_count} !==
        {1'b1, 1'b0, 12'd0, 32'd0, 4'b0000, 13'd0} || got_q.size() != 0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b we=%b addr=%h wdata=%h rst=%b busy=%b done=%b err=%b wc=%0d writes=%0d",
               s_ready, mem_we, mem_addr, mem_wdata, cpu_rst_n, busy, done, err, word_count, got_q.size());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(fr, 0, 1'b0, "after_reset");
    fr = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
    run_frame(fr, 0, 1'b0, "second_image");
  endtask

  task automatic test_max();
    logic [7:0] s;
    fr.delete();
    fr.push_back(8'h00);
    fr.push_back(8'h10);
    s = 8'd0;
    for (int i = 0; i < MAX_WORDS; i++) begin
      for (int k = 0; k < 4; k++) begin
        fr.push_back(8'(i >> (8*k)));
        s = s + 8'(i >> (8*k));
      end
    end
    fr.push_back(s);
    run_frame(fr, 0, 1'b0, "max_size");
    n_checks++;
    if (mem_addr !== 12'hFFF || word_count !== 13'd4096 || done !== 1'b1 ||
        got_q.size() == 0 || got_q[got_q.size()-1] !== {12'hFFF, 32'h00000FFF}) begin
      n_fail++;
      $display("FAIL max_last_write: addr=%h word_count=%0d done=%b want fff 4096 1", mem_addr, word_count, done);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_header_errors();
    test_throttled();
    test_reset_reload();
    test_max();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
